// File: rtl/divider_if.sv
// divider_if: EX-stage request, stall and HI/LO result bundle for the divider.
interface divider_if #(parameter int WIDTH = 32);
  logic               div_en;
  logic               div_signed;
  logic               flush;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               div_stall;
  logic [2*WIDTH-1:0] result;
  logic               result_valid;
  modport master(output div_en, div_signed, flush, opa, opb, input div_stall, result, result_valid);
  modport slave(input div_en, div_signed, flush, opa, opb, output div_stall, result, result_valid);
endinterface

// File: rtl/divider.sv
// divider: multi-cycle radix-2 restoring DIV/DIVU producing {HI, LO} and the EX stall.
module divider #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  divider_if.slave d
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, dsr, rem, rem_nxt, dvd_nxt;
  logic q_neg, r_neg;
  logic [WIDTH:0] sh, trial;
  always_comb begin
    sh = {rem, dvd[WIDTH-1]};
    trial = sh - {1'b0, dsr};
    rem_nxt = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_nxt = {dvd[WIDTH-2:0], ~trial[WIDTH]};
  end
  assign d.div_stall = !d.flush && ((state == IDLE && d.div_en) || state == BUSY);
  // The result is registered on the final step so it is already valid in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dvd <= '0;
      dsr <= '0;
      rem <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      d.result <= '0;
      d.result_valid <= 1'b0;
    end else begin
      d.result_valid <= 1'b0;
      if (d.flush) state <= IDLE;
      else case (state)
        IDLE: if (d.div_en) begin
          dvd <= (d.div_signed && d.opa[WIDTH-1]) ? -d.opa : d.opa;
          dsr <= (d.div_signed && d.opb[WIDTH-1]) ? -d.opb : d.opb;
          q_neg <= d.div_signed && (d.opa[WIDTH-1] ^ d.opb[WIDTH-1]);
          r_neg <= d.div_signed && d.opa[WIDTH-1];
          rem <= '0;
          cnt <= '0;
          state <= BUSY;
        end
        BUSY: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            d.result <= {r_neg ? -rem_nxt : rem_nxt, q_neg ? -dvd_nxt : dvd_nxt};
            d.result_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// tb_divider: random and directed DIV/DIVU checks against a cycle-level arithmetic model.
module tb_divider;
  localparam int W = 32;
  logic clk = 0;
  logic rst = 1;
  logic arm = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  divider_if #(.WIDTH(W)) bus();
  divider #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .d(bus));
  int m_phase = 0;
  int m_left = 0;
  logic m_valid = 0;
  logic [63:0] m_exp = 0;
  logic [63:0] m_res = 0;
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ma, mb, q, r;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (mb == 0) begin
      q = '1;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r, q};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  // Phase 0 idle, 1 dividing (32 cycles), 2 result cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_valid <= 0;
      m_res <= 0;
    end else if (bus.flush) begin
      m_phase <= 0;
      m_valid <= 0;
    end else if (m_phase == 0) begin
      m_valid <= 0;
      if (bus.div_en) begin
        m_phase <= 1;
        m_left <= 32;
        m_exp <= ref_div(bus.opa, bus.opb, bus.div_signed);
      end
    end else if (m_phase == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_phase <= 2;
        m_valid <= 1;
        m_res <= m_exp;
      end
    end else begin
      m_phase <= 0;
      m_valid <= 0;
    end
  end
  always @(negedge clk) if (arm) begin
    chk("stall", 64'(bus.div_stall), 64'(!bus.flush && ((m_phase == 0 && bus.div_en) || m_phase == 1)));
    chk("valid", 64'(bus.result_valid), 64'(m_valid));
    chk("result", bus.result, m_res);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.opa = a;
    bus.opb = b;
    bus.div_signed = s;
    bus.div_en = 1;
  endtask
  task automatic wait_valid(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.result_valid) begin
        k = i;
        return;
      end
      step();
    end
  endtask
  task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] lit);
    int k;
    step();
    start(a, b, s);
    step();
    bus.div_en = 0;
    bus.opa = $urandom;
    bus.opb = $urandom;
    wait_valid(k);
    chk({nm, "_latency"}, 64'(k), 64'd33);
    chk(nm, bus.result, lit);
  endtask
  function automatic logic [31:0] pick();
    int c;
    c = $urandom_range(0, 7);
    return c == 0 ? 32'h0 : c == 1 ? 32'h80000000 : c == 2 ? 32'hFFFFFFFF : c == 3 ? 32'h1 : $urandom;
  endfunction
  initial begin
    int k;
    bus.div_en = 0;
    bus.div_signed = 0;
    bus.flush = 0;
    bus.opa = 0;
    bus.opb = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    arm = 1;
    @(negedge clk);
    chk("reset_result", bus.result, 64'h0);
    chk("reset_valid", 64'(bus.result_valid), 64'h0);
    directed("divu_100_7", 32'd100, 32'd7, 0, 64'h00000002_0000000E);
    directed("div_m7_2", 32'hFFFFFFF9, 32'h2, 1, 64'hFFFFFFFF_FFFFFFFD);
    directed("div_7_m2", 32'h7, 32'hFFFFFFFE, 1, 64'h00000001_FFFFFFFD);
    directed("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1, 64'h00000000_80000000);
    directed("divu_max_1", 32'hFFFFFFFF, 32'h1, 0, 64'h00000000_FFFFFFFF);
    directed("divu_5_0", 32'h5, 32'h0, 0, 64'h00000005_FFFFFFFF);
    // Flush at T10 of a division, then a fresh DIVU 9/3 at T11.
    step();
    start(32'd100, 32'd3, 0);
    step();
    bus.div_en = 0;
    repeat (9) step();
    bus.flush = 1;
    @(negedge clk);
    chk("flush_stall", 64'(bus.div_stall), 64'h0);
    step();
    bus.flush = 0;
    chk("flush_hold", bus.result, 64'h00000005_FFFFFFFF);
    start(32'd9, 32'd3, 0);
    step();
    bus.div_en = 0;
    wait_valid(k);
    chk("after_flush_latency", 64'(k), 64'd33);
    chk("after_flush", bus.result, 64'h00000000_00000003);
    // Reset at T20 of a division.
    step();
    start(32'd1000, 32'd7, 0);
    step();
    bus.div_en = 0;
    repeat (19) step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("midrst_result", bus.result, 64'h0);
    chk("midrst_valid", 64'(bus.result_valid), 64'h0);
    chk("midrst_stall", 64'(bus.div_stall), 64'h0);
    // Back-to-back: div_en held across DONE so the second DIVU starts at T34.
    step();
    start(32'd10, 32'd3, 0);
    step();
    bus.opa = 32'd20;
    bus.opb = 32'd6;
    wait_valid(k);
    chk("b2b1_latency", 64'(k), 64'd33);
    chk("b2b1", bus.result, 64'h00000001_00000003);
    step();
    step();
    bus.div_en = 0;
    wait_valid(k);
    chk("b2b2_latency", 64'(k), 64'd33);
    chk("b2b2", bus.result, 64'h00000002_00000003);
    repeat (150) begin
      step();
      start(pick(), pick(), 1'($urandom));
      step();
      bus.div_en = 0;
      bus.opa = $urandom;
      bus.opb = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 30)) step();
        bus.flush = 1;
        step();
        bus.flush = 0;
      end else begin
        wait_valid(k);
        chk("rand_latency", 64'(k), 64'd33);
      end
    end
    step();
    arm = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider.md
# divider

Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, sitting in the EX stage directly upstream of the hazard unit. It produces `div_stall`, which the hazard unit uses to stall F/D/E and bubble M while a division is in progress. It also produces the 64-bit {HI, LO} result that EX hands to the HI/LO write path.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `div_en`  in  1  EX holds a valid DIV/DIVU instruction.
- `div_signed`  in  1  1 = DIV (signed), 0 = DIVU.
- `flush`  in  1  exception flush (`flush_exceptionM`); cancels any division.
- `opa`  in  32  dividend (forwarded rs value in EX).
- `opb`  in  32  divisor (forwarded rt value in EX).
- `div_stall`  out  1  combinational; high while the EX-stage division is unfinished.
- `result`  out  64  registered result, {remainder (HI), quotient (LO)}.
- `result_valid`  out  1  registered; high for exactly one cycle when `result` is fresh.

## Operation
- FSM states: IDLE, BUSY, DONE. Cycle counter `cnt` is 5 bits and counts 0..31.
- IDLE: if `div_en && !flush`:
  - latch |opa| and |opb|; magnitudes are taken only when `div_signed`, otherwise raw values.
  - latch quotient sign = `div_signed & (opa[31]^opb[31])` and remainder sign = `div_signed & opa[31]`.
  - clear the partial remainder; set `cnt=0`; go to BUSY.
- BUSY: perform one restoring step per cycle:
  - shift {rem, dvd} left by 1.
  - compute trial = rem − divisor on 33 bits.
  - if trial is non-negative, rem = trial and the quotient bit is 1; otherwise the quotient bit is 0.
  - `cnt` increments each step.
  - after the step with `cnt==31`, go to DONE.
- DONE: `result` is written with the sign fix applied:
  - quotient is negated if the quotient sign is set.
  - remainder is negated if the remainder sign is set.
  - `result_valid=1`; go to IDLE unconditionally.
- `div_stall = !flush && ((state==IDLE && div_en) || state==BUSY)`. It is low in DONE, so EX advances in the DONE cycle.
- Arithmetic corner cases:
  - magnitude of 0x80000000 is treated as unsigned 0x80000000.
  - signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - divide by zero raises no exception and keeps the same latency. Unsigned result: quotient 0xFFFFFFFF, remainder = dividend. Signed result: the same unsigned magnitudes, then the sign fix.
- `flush` in any state:
  - `div_stall` is low in that cycle and the next state is IDLE.
  - `result` and `result_valid` are not updated (`result_valid=0`).
- `rst` (priority over everything) sets state IDLE, `cnt=0`, `result=0`, `result_valid=0`, and all internal registers to 0. `div_stall` is therefore 0 after reset unless `div_en` is high.
- `result` holds its value until the next DONE or reset.

## Timing
- T0: IDLE with `div_en`. `div_stall=1` combinationally in the same cycle; operands are latched at the T0 edge.
- T1..T32: BUSY with `div_stall=1`. That gives 33 stall cycles in total, T0..T32.
- T33: DONE.
  - `div_stall=0`, `result_valid=1`, `result` is final.
  - The hazard unit releases F/D/E and the DIV leaves EX at the T33 edge.
- T34: IDLE. A back-to-back DIV now in EX starts at T34, with no dead cycle beyond DONE.
- `opa`/`opb` may change after T0 and are ignored; EX is stalled anyway.
- Mid-operation reset: `result_valid=0`, `result=0` the cycle after the reset edge.

## Test plan
- DIVU 100/7 with `div_en` at T0 -> `div_stall` high T0..T32, low at T33; `result_valid` pulses at T33 only; `result`={0x00000002, 0x0000000E}.
- DIV −7/2 (0xFFFFFFF9/0x2) -> {0xFFFFFFFF, 0xFFFFFFFD}.
- DIV 7/−2 -> {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
- DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- DIVU 5/0 -> {0x00000005, 0xFFFFFFFF} after 33 stall cycles, no exception.
- Start at T0 with prior `result`=R, assert `flush` at T10 -> `div_stall`=0 at T10, IDLE at T11, `result_valid` never asserted, `result` stays R. A new DIVU 9/3 started at T11 -> {0, 3} at T44.
- `rst` asserted at T20 mid-division -> at T21 `result`=0, `result_valid`=0, `div_stall`=0 with `div_en` low. Back-to-back DIVUs 10/3 then 20/6 -> valid pulses at T33 ({1,3}) and T67 ({2,3}).
